// File: rtl/prod_ctrl_n_pkg.sv
// -----------------------------------------------------------------------------
// prod_ctrl_n_pkg
//   Shared definitions for the producer/buffer controller:
//     - state_t     : controller state encoding
//     - LED_*       : bit positions of each state on the led output
//     - MAX_CH      : upper bound on the number of producer channels
//     - lowest_index: lowest-set-bit priority encoder used for channel select
// -----------------------------------------------------------------------------
package prod_ctrl_n_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COMM  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam int LED_IDLE  = 0;
    localparam int LED_COMM  = 1;
    localparam int LED_WAIT  = 2;
    localparam int LED_DRAIN = 3;

    localparam int MAX_CH = 8;

    // Index of the lowest set bit of req; 0 when req is all zero (callers
    // only use the result when at least one bit is set).
    function automatic logic [2:0] lowest_index(input logic [MAX_CH-1:0] req);
        logic [2:0] idx;
        idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/prod_ctrl_n_edge.sv
// -----------------------------------------------------------------------------
// edge_detector
//   Turns a raw button level into a single-cycle registered rising-edge pulse.
//   The input is first captured in a register so the edge comparison never
//   looks at the raw pin directly. A level that is high at clock edge k gives
//   a pulse during the cycle after edge k+1; a held button yields one pulse.
//
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset (clears any pending pulse)
//   din   in  raw button level
//   pulse out one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic sync_q;
    logic prev_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its source, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= din;
            prev_q <= sync_q;
            pulse  <= sync_q & ~prev_q;
        end
    end

endmodule

// File: rtl/prod_ctrl_n.sv
// -----------------------------------------------------------------------------
// prod_ctrl_n
//   Arbitrates NUM_CH data producers into the single write port of the
//   clock-domain-crossing buffer. Production pauses while the buffer is full,
//   a stop drains the buffer before returning to idle, and the state is shown
//   one-hot on the LEDs. Optional channel re-targeting, drain timeout with a
//   sticky error flag, and a count of words written since the last start.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         raw start buttons, one per channel
//   stop          raw stop button (all channels)
//   buffer_full   buffer write side full
//   buffer_empty  buffer read side empty
//   data_valid_2  consumer still holds a valid word
//   ch_valid      per-channel producer output valid
//   ch_data       packed producer data, channel i at [i*DATA_W +: DATA_W]
//   ch_en         one-hot producer enable
//   data_1_en     buffer write enable
//   data_1        buffer write data (0 when not writing)
//   active_ch     currently selected channel
//   led           one-hot state: [0]IDLE [1]COMM [2]WAIT [3]DRAIN
//   drain_err     sticky: last drain ended by timeout
//   word_count    words written since the last IDLE->COMM
// -----------------------------------------------------------------------------
module prod_ctrl_n
    import prod_ctrl_n_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int DATA_W        = 16,
    parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int ALLOW_SWITCH  = 0,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        start,
    input  logic                     stop,
    input  logic                     buffer_full,
    input  logic                     buffer_empty,
    input  logic                     data_valid_2,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_en,
    output logic                     data_1_en,
    output logic [DATA_W-1:0]        data_1,
    output logic [CH_W-1:0]          active_ch,
    output logic [3:0]               led,
    output logic                     drain_err,
    output logic [CNT_W-1:0]         word_count
);

    // Drain counter only needs to reach DRAIN_TIMEOUT-1.
    localparam int               TMO_W    = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam bit               TMO_EN   = (DRAIN_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(DRAIN_TIMEOUT - 1) : '0;

    // ------------------------------------------------------------------
    // Button edge detection: starts in [NUM_CH-1:0], stop in [NUM_CH]
    // ------------------------------------------------------------------
    logic [NUM_CH:0]   btn_raw;
    logic [NUM_CH:0]   btn_pulse;
    logic [NUM_CH-1:0] start_p;
    logic              stop_p;

    assign btn_raw = {stop, start};

    for (genvar i = 0; i <= NUM_CH; i++) begin : g_edge
        edge_detector u_edge (
            .clk  (clk),
            .rst  (rst),
            .din  (btn_raw[i]),
            .pulse(btn_pulse[i])
        );
    end

    assign start_p = btn_pulse[NUM_CH-1:0];
    assign stop_p  = btn_pulse[NUM_CH];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [CH_W-1:0]   active_q, active_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  wc_q, wc_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic [NUM_CH-1:0] active_oh;
    logic [NUM_CH-1:0] other_p;
    logic              switch_req;
    logic [CH_W-1:0]   first_start;
    logic [CH_W-1:0]   first_other;

    assign active_oh   = NUM_CH'(1) << active_q;
    // A re-target only counts when it names a channel other than the current one.
    assign other_p     = start_p & ~active_oh;
    assign switch_req  = (ALLOW_SWITCH != 0) && (other_p != '0);
    assign first_start = CH_W'(lowest_index(MAX_CH'(start_p)));
    assign first_other = CH_W'(lowest_index(MAX_CH'(other_p)));

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        err_d    = err_q;
        wc_d     = wc_q;
        tmo_d    = tmo_q;

        if (data_1_en) wc_d = wc_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (start_p != '0) begin
                    state_d  = S_COMM;
                    active_d = first_start;
                    wc_d     = '0;
                    err_d    = 1'b0;
                end
            end
            S_COMM: begin
                if (stop_p) begin
                    state_d = S_DRAIN;
                    tmo_d   = '0;
                end else if (buffer_full) begin
                    state_d = S_WAIT;
                end else if (switch_req) begin
                    active_d = first_other;
                end
            end
            S_WAIT: begin
                if (stop_p) begin
                    state_d = S_DRAIN;
                    tmo_d   = '0;
                end else if (!buffer_full) begin
                    state_d = S_COMM;
                end else if (switch_req) begin
                    active_d = first_other;
                end
            end
            S_DRAIN: begin
                // A clean drain wins over a timeout landing in the same cycle.
                if (buffer_empty && !data_valid_2) begin
                    state_d = S_IDLE;
                end else if (TMO_EN) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            active_q <= '0;
            err_q    <= 1'b0;
            wc_q     <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            err_q    <= err_d;
            wc_q     <= wc_d;
            tmo_q    <= tmo_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Producers are enabled only while actually writing; a full buffer gates
    // the enable in the same cycle, before the state has moved to WAIT.
    always_comb begin
        ch_en = '0;
        if (state_q == S_COMM && !buffer_full) ch_en = active_oh;
    end

    assign data_1_en = |(ch_en & ch_valid);
    assign data_1    = data_1_en ? ch_data[int'(active_q)*DATA_W +: DATA_W] : '0;

    always_comb begin
        led = '0;
        unique case (state_q)
            S_IDLE:  led[LED_IDLE]  = 1'b1;
            S_COMM:  led[LED_COMM]  = 1'b1;
            S_WAIT:  led[LED_WAIT]  = 1'b1;
            S_DRAIN: led[LED_DRAIN] = 1'b1;
        endcase
    end

    assign active_ch  = active_q;
    assign drain_err  = err_q;
    assign word_count = wc_q;

endmodule
